// File: rtl/gatebach_result_merger.sv
// gatebach_result_merger
// Merges the 2048-bit sieve slices of CORE_NUM cores by bitwise AND into a
// 64 x 32-bit buffer. Once every core has signalled completion, the buffer is
// scanned bit by bit and each surviving bit is streamed out as its odd number
// (start_addr + 2*bit) on a valid/ready interface.
//
// Optional feature macro: GATEBACH_MERGE_STATS_EN
//   defined   -> survivor_cnt counts accepted beats of the current job
//   undefined -> survivor_cnt is tied to zero and no counter is built
module gatebach_result_merger #(
    parameter int CORE_NUM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] start_addr,
    input  logic        slice_start,
    input  logic        cs_in,
    input  logic [5:0]  add_in,
    input  logic [31:0] data_in,
    input  logic        store_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic        done,
    output logic [11:0] survivor_cnt
);

    // Core counter must hold values 0..CORE_NUM-1; at least one bit wide.
    localparam int CNT_W = (CORE_NUM < 2) ? 1 : $clog2(CORE_NUM + 1);
    localparam logic [CNT_W-1:0] LAST_CORE = CNT_W'(CORE_NUM - 1);
    localparam logic [10:0] LAST_BIT = 11'd2047;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        SCAN,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       buf_q [64];
    logic [31:0]       buf_d [64];
    logic [63:0]       base_q, base_d;
    logic [CNT_W-1:0]  core_cnt_q, core_cnt_d;
    logic [10:0]       ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [63:0]       out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              store_prev_q, store_prev_d;

    logic              store_rise;
    logic              cur_bit;
    logic [63:0]       beat_value;
    logic              beat_accept;

    assign store_rise  = store_done & ~store_prev_q;
    assign cur_bit     = buf_q[ptr_q[10:5]][ptr_q[4:0]];
    assign beat_value  = base_q + {52'd0, ptr_q, 1'b0};
    assign beat_accept = out_valid_q & out_ready;

    // Next-state logic: slice setup, core merge, bit scan and output staging.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        base_d       = base_q;
        core_cnt_d   = core_cnt_q;
        ptr_d        = ptr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        done_d       = 1'b0;
        store_prev_d = store_done;

        case (state_q)
            IDLE: begin
                if (slice_start) begin
                    for (int i = 0; i < 64; i++) begin
                        buf_d[i] = '1;
                    end
                    base_d     = start_addr;
                    core_cnt_d = '0;
                    ptr_d      = '0;
                    state_d    = COLLECT;
                end
            end

            COLLECT: begin
                if (cs_in) begin
                    buf_d[add_in] = buf_q[add_in] & data_in;
                end
                if (store_rise) begin
                    if (core_cnt_q == LAST_CORE) begin
                        state_d = SCAN;
                    end else begin
                        core_cnt_d = core_cnt_q + CNT_W'(1);
                    end
                end
            end

            SCAN: begin
                if (out_valid_q) begin
                    // The pointer stays on the set bit until its beat is taken.
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        ptr_d       = ptr_q + 11'd1;
                        if (ptr_q == LAST_BIT) begin
                            state_d = FIN;
                            done_d  = 1'b1;
                        end
                    end
                end else if (cur_bit) begin
                    out_valid_d = 1'b1;
                    out_data_d  = beat_value;
                end else begin
                    ptr_d = ptr_q + 11'd1;
                    if (ptr_q == LAST_BIT) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset leaves an idle merger with a full buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < 64; i++) begin
                buf_q[i] <= '1;
            end
            base_q       <= '0;
            core_cnt_q   <= '0;
            ptr_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            store_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            base_q       <= base_d;
            core_cnt_q   <= core_cnt_d;
            ptr_q        <= ptr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            store_prev_q <= store_prev_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef GATEBACH_MERGE_STATS_EN
    logic [11:0] surv_cnt_q, surv_cnt_d;

    // Survivor counter: cleared when a slice opens, bumped on every accepted beat.
    always_comb begin
        surv_cnt_d = surv_cnt_q;
        if (state_q == IDLE && slice_start) begin
            surv_cnt_d = '0;
        end else if (beat_accept) begin
            surv_cnt_d = surv_cnt_q + 12'd1;
        end
    end

    // Survivor counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            surv_cnt_q <= '0;
        end else begin
            surv_cnt_q <= surv_cnt_d;
        end
    end

    assign survivor_cnt = surv_cnt_q;
`else
    logic unused_accept;
    assign unused_accept = beat_accept;
    assign survivor_cnt  = 12'd0;
`endif

endmodule

// File: tb/tb_gatebach_result_merger.sv
// tb_gatebach_result_merger
// Directed bench for the result merger. A CORE_NUM=1 instance carries most of
// the jobs; a CORE_NUM=2 instance shares the write bus for the two-core job.
// A bit-level model of the merged slice predicts the survivor stream.
module tb_gatebach_result_merger;

`ifdef GATEBACH_MERGE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] start_addr;
    logic        cs_in;
    logic [5:0]  add_in;
    logic [31:0] data_in;

    logic        slice_start1, store_done1, out_ready1;
    logic        out_valid1, busy1, done1;
    logic [63:0] out_data1;
    logic [11:0] survivor_cnt1;

    logic        slice_start2, store_done2, out_ready2;
    logic        out_valid2, busy2, done2;
    logic [63:0] out_data2;
    logic [11:0] survivor_cnt2;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    bit          model_bits [2048];
    logic [63:0] model_base;

    int          nBeats, nBad;
    logic [63:0] firstBeat, lastBeat;
    bit          sawDone;

    always #5 clk = ~clk;

    gatebach_result_merger #(.CORE_NUM(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .start_addr   (start_addr),
        .slice_start  (slice_start1),
        .cs_in        (cs_in),
        .add_in       (add_in),
        .data_in      (data_in),
        .store_done   (store_done1),
        .out_valid    (out_valid1),
        .out_ready    (out_ready1),
        .out_data     (out_data1),
        .busy         (busy1),
        .done         (done1),
        .survivor_cnt (survivor_cnt1)
    );

    gatebach_result_merger #(.CORE_NUM(2)) dut2 (
        .clk          (clk),
        .rst          (rst),
        .start_addr   (start_addr),
        .slice_start  (slice_start2),
        .cs_in        (cs_in),
        .add_in       (add_in),
        .data_in      (data_in),
        .store_done   (store_done2),
        .out_valid    (out_valid2),
        .out_ready    (out_ready2),
        .out_data     (out_data2),
        .busy         (busy2),
        .done         (done2),
        .survivor_cnt (survivor_cnt2)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One word write on the shared core bus; tracked writes also update the model.
    task automatic applyStimulus(input int addr, input logic [31:0] data, input bit tracked);
        @(negedge clk);
        cs_in   = 1'b1;
        add_in  = addr[5:0];
        data_in = data;
        if (tracked) begin
            for (int b = 0; b < 32; b++) begin
                model_bits[addr * 32 + b] = model_bits[addr * 32 + b] & data[b];
            end
        end
        @(negedge clk);
        cs_in = 1'b0;
    endtask

    task automatic startSlice(input bit sel, input logic [63:0] addr);
        @(negedge clk);
        start_addr = addr;
        if (sel) slice_start2 = 1'b1;
        else     slice_start1 = 1'b1;
        for (int i = 0; i < 2048; i++) model_bits[i] = 1'b1;
        model_base = addr;
        @(negedge clk);
        slice_start1 = 1'b0;
        slice_start2 = 1'b0;
    endtask

    task automatic coreDone(input bit sel);
        @(negedge clk);
        if (sel) store_done2 = 1'b1;
        else     store_done1 = 1'b1;
        repeat (4) @(negedge clk);
        store_done1 = 1'b0;
        store_done2 = 1'b0;
    endtask

    // Drains the survivor stream until done, comparing each beat to the model.
    // The first beat can be held off for stallCycles with out_ready low.
    task automatic collectBeats(input bit sel, input int stallCycles, output int beats,
                                output logic [63:0] first, output logic [63:0] last,
                                output int bad, output bit gotDone);
        int          idx = 0;
        int          held = 0;
        logic [63:0] heldData = '0;
        logic        curValid, curDone, rdy;
        logic [63:0] curData;
        beats = 0; bad = 0; gotDone = 1'b0; first = '0; last = '0;
        for (int cyc = 0; cyc < 6000 && !gotDone; cyc++) begin
            @(negedge clk);
            curValid = sel ? out_valid2 : out_valid1;
            curData  = sel ? out_data2  : out_data1;
            curDone  = sel ? done2      : done1;
            if (curDone) gotDone = 1'b1;
            rdy = 1'b1;
            if (held > 0 && beats == 0 && !curValid) bad++;
            if (curValid && beats == 0) begin
                if (held > 0 && curData !== heldData) bad++;
                heldData = curData;
                if (held < stallCycles) begin
                    held++;
                    rdy = 1'b0;
                end
            end
            if (sel) out_ready2 = rdy;
            else     out_ready1 = rdy;
            if (curValid && rdy) begin
                while (idx < 2048 && !model_bits[idx]) idx++;
                if (idx >= 2048 || curData !== model_base + 64'(2 * idx)) bad++;
                idx++;
                beats++;
                if (beats == 1) first = curData;
                last = curData;
            end
        end
        out_ready1 = 1'b0;
        out_ready2 = 1'b0;
    endtask

    task automatic finishCheck(input bit sel, input string tag);
        @(negedge clk);
        checkOutput({tag, "_done_pulse_end"}, sel ? done2 : done1, 1'b0);
        checkOutput({tag, "_idle_busy"},      sel ? busy2 : busy1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start_addr = '0; cs_in = 1'b0; add_in = '0; data_in = '0;
        slice_start1 = 1'b0; store_done1 = 1'b0; out_ready1 = 1'b0;
        slice_start2 = 1'b0; store_done2 = 1'b0; out_ready2 = 1'b0;
        model_base = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", out_valid1, 1'b0);
        checkOutput("rst_out_data", out_data1, 64'd0);
        checkOutput("rst_busy", busy1, 1'b0);
        checkOutput("rst_done", done1, 1'b0);
        checkOutput("rst_survivor_cnt", survivor_cnt1, 12'd0);
        checkOutput("rst_out_valid2", out_valid2, 1'b0);
        rst = 1'b0;

        // Full slice: every bit survives except bit 0.
        startSlice(1'b0, 64'd201);
        checkOutput("full_busy_after_start", busy1, 1'b1);
        for (int k = 0; k < 64; k++) applyStimulus(k, (k == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF, 1'b1);
        coreDone(1'b0);
        collectBeats(1'b0, 0, nBeats, firstBeat, lastBeat, nBad, sawDone);
        checkOutput("full_beats", nBeats, 2047);
        checkOutput("full_first", firstBeat, 64'd203);
        checkOutput("full_last", lastBeat, 64'd4295);
        checkOutput("full_bad_beats", nBad, 0);
        checkOutput("full_done", sawDone, 1'b1);
        finishCheck(1'b0, "full");
        checkOutput("full_survivor_cnt", survivor_cnt1, STATS_ON ? 12'd2047 : 12'd0);

        // Only the top bit survives; its beat is stalled for 10 cycles.
        startSlice(1'b0, 64'd201);
        for (int k = 0; k < 64; k++) applyStimulus(k, (k == 63) ? 32'h8000_0000 : 32'h0, 1'b1);
        coreDone(1'b0);
        collectBeats(1'b0, 10, nBeats, firstBeat, lastBeat, nBad, sawDone);
        checkOutput("top_beats", nBeats, 1);
        checkOutput("top_first", firstBeat, 64'd4295);
        checkOutput("top_stall_bad", nBad, 0);
        checkOutput("top_done", sawDone, 1'b1);
        finishCheck(1'b0, "top");
        checkOutput("top_survivor_cnt", survivor_cnt1, STATS_ON ? 12'd1 : 12'd0);

        // Two cores: 0xF AND 0x5 leaves bits 0 and 2; scan waits for core B.
        startSlice(1'b1, 64'd201);
        for (int k = 0; k < 64; k++) applyStimulus(k, (k == 0) ? 32'h0000_000F : 32'h0, 1'b1);
        coreDone(1'b1);
        repeat (6) @(negedge clk);
        checkOutput("two_core_no_early_scan", out_valid2, 1'b0);
        checkOutput("two_core_still_busy", busy2, 1'b1);
        for (int k = 0; k < 64; k++) applyStimulus(k, (k == 0) ? 32'h0000_0005 : 32'h0, 1'b1);
        coreDone(1'b1);
        collectBeats(1'b1, 0, nBeats, firstBeat, lastBeat, nBad, sawDone);
        checkOutput("two_core_beats", nBeats, 2);
        checkOutput("two_core_first", firstBeat, 64'd201);
        checkOutput("two_core_last", lastBeat, 64'd205);
        checkOutput("two_core_bad", nBad, 0);
        checkOutput("two_core_done", sawDone, 1'b1);
        finishCheck(1'b1, "two_core");

        // Stray slice_start in COLLECT and a write during SCAN must be ignored.
        startSlice(1'b0, 64'd301);
        for (int k = 0; k < 64; k++) begin
            applyStimulus(k, (k == 0) ? 32'h0000_0003 : ((k == 63) ? 32'h0000_0001 : 32'h0), 1'b1);
        end
        @(negedge clk);
        start_addr   = 64'd999;
        slice_start1 = 1'b1;
        @(negedge clk);
        slice_start1 = 1'b0;
        coreDone(1'b0);
        applyStimulus(63, 32'h0, 1'b0);
        collectBeats(1'b0, 0, nBeats, firstBeat, lastBeat, nBad, sawDone);
        checkOutput("ignore_beats", nBeats, 3);
        checkOutput("ignore_first", firstBeat, 64'd301);
        checkOutput("ignore_last", lastBeat, 64'd4333);
        checkOutput("ignore_bad", nBad, 0);
        checkOutput("ignore_done", sawDone, 1'b1);
        finishCheck(1'b0, "ignore");

        // Reset in the middle of a scan, then a fresh job.
        startSlice(1'b0, 64'd501);
        coreDone(1'b0);
        repeat (3) @(negedge clk);
        checkOutput("midscan_beat_pending", out_valid1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midscan_rst_out_valid", out_valid1, 1'b0);
        checkOutput("midscan_rst_busy", busy1, 1'b0);
        checkOutput("midscan_rst_out_data", out_data1, 64'd0);
        checkOutput("midscan_rst_survivor_cnt", survivor_cnt1, 12'd0);
        @(negedge clk);
        rst = 1'b0;
        startSlice(1'b0, 64'd1001);
        for (int k = 0; k < 64; k++) applyStimulus(k, (k == 5) ? 32'h0001_0000 : 32'h0, 1'b1);
        coreDone(1'b0);
        collectBeats(1'b0, 0, nBeats, firstBeat, lastBeat, nBad, sawDone);
        checkOutput("after_rst_beats", nBeats, 1);
        checkOutput("after_rst_first", firstBeat, 64'd1353);
        checkOutput("after_rst_bad", nBad, 0);
        checkOutput("after_rst_done", sawDone, 1'b1);
        finishCheck(1'b0, "after_rst");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/gatebach_result_merger.md
GATEBACH_RESULT_MERGER -- requirements
Module: gatebach_result_merger

Interface
REQ-001 SHALL have parameter CORE_NUM, default 1, meaning the number of sieve cores whose 2048-bit slices are AND-merged per job.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-004 SHALL have port start_addr, input, 64 bits, the odd number represented by slice bit 0; bit i represents start_addr+2*i.
REQ-005 SHALL have port slice_start, input, 1 bit, a one-cycle pulse that opens a new slice.
REQ-006 SHALL have ports cs_in (input, 1 bit), add_in (input, 6 bits) and data_in (input, 32 bits), the core word-write bus; word k holds slice bits 32k..32k+31, LSB first.
REQ-007 SHALL have port store_done, input, 1 bit, the core-complete level; each rising edge counts one core.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, 64), a survivor-number stream.
REQ-009 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and survivor_cnt (output, 12).

Function
REQ-010 SHALL implement FSM states IDLE, COLLECT, SCAN and FIN.
REQ-011 SHALL, in IDLE on slice_start, set all 64x32 buffer bits to 1, latch start_addr, clear the core counter and survivor_cnt, and enter COLLECT; busy=1 from the next cycle.
REQ-012 SHALL ignore slice_start outside IDLE.
REQ-013 SHALL, in COLLECT, on cs_in=1, perform buffer[add_in] <= buffer[add_in] AND data_in, and SHALL ignore cs_in in other states.
REQ-014 SHALL detect a store_done rising edge using a registered previous value; a level held high counts once.
REQ-015 SHALL enter SCAN the cycle after the CORE_NUM-th rising edge; a cs_in write in that same edge cycle SHALL still be applied.
REQ-016 SHALL, in SCAN, examine one bit per cycle using an 11-bit pointer from 0 to 2047; a zero bit advances the pointer with no output.
REQ-017 SHALL, for a set bit, assert out_valid the next cycle with out_data=latched start_addr+2*pointer (64-bit wrap), and stall the pointer until out_valid&&out_ready.
REQ-018 SHALL hold out_data stable while out_valid=1 and out_ready=0, and SHALL deassert out_valid after the handshake if no further set bit has been reached.
REQ-019 SHALL, after bit 2047 is processed and its beat is accepted, enter FIN, pulse done for one cycle, and return to IDLE with busy=0.
REQ-020 SHALL produce survivors in strictly ascending order and output each exactly once.

Reset
REQ-021 SHALL, on rst, asynchronously force IDLE with busy=0, done=0, out_valid=0, out_data=0, survivor_cnt=0, the core counter and pointer at 0, the store_done history at 0, and all buffer bits at 1.
REQ-022 SHALL, when rst is asserted mid-COLLECT or mid-SCAN, discard the partial job and emit no further beats.

Configuration
REQ-023 SHALL, with GATEBACH_MERGE_STATS_EN defined, increment survivor_cnt on each accepted beat and hold its value until the next slice_start.
REQ-024 SHALL, without GATEBACH_MERGE_STATS_EN, tie survivor_cnt to 0 and synthesize no counter logic.

Verification
REQ-025 SHALL cover: start_addr=201, CORE_NUM=1, 64 writes of 0xFFFFFFFF except word0=0xFFFFFFFE, one store_done edge -> 2047 beats, first 203, last 4295, survivor_cnt=2047, done pulse.
REQ-026 SHALL cover: all words 0 except word63=0x80000000 -> exactly one beat with out_data=4295, then done.
REQ-027 SHALL cover: CORE_NUM=2, core A word0=0x0000000F, core B word0=0x00000005, others 0 -> beats 201 and 205 only; SCAN starts only after the second store_done edge.
REQ-028 SHALL cover: out_ready held low for 10 cycles on the first beat -> out_data is stable, there are no duplicates, and order is preserved.
REQ-029 SHALL cover: slice_start pulsed during COLLECT, and cs_in during SCAN -> both ignored and the result is unchanged.
REQ-030 SHALL cover: rst asserted mid-SCAN -> out_valid=0 immediately, IDLE, and the next slice_start job completes correctly.
